// File: rtl/banff_sfr_pkg.sv
// Shared definitions for the SFR subsystem: op codes, access-unit state encoding,
// and default geometry used by sfr_file, the decoder and the access unit.
package banff_sfr_pkg;

  localparam int unsigned SFR_ADDR_WIDTH    = 6;
  localparam int unsigned SFR_DATA_WIDTH    = 8;
  localparam int unsigned SFR_DEPTH_DEFAULT = 64;

  typedef enum logic [2:0] {
    OP_READ  = 3'b000,
    OP_WRITE = 3'b001,
    OP_SET   = 3'b010,
    OP_CLR   = 3'b011,
    OP_TGL   = 3'b100
  } sfr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } sfr_state_e;

  // Codes 101..111 are reserved and rejected by the access unit.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_TGL;
  endfunction

endpackage

// File: rtl/sfr_bitop.sv
// Combinational new-value computation for SFR writes and atomic bit operations.
module sfr_bitop
  import banff_sfr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SFR_DATA_WIDTH
) (
  input  sfr_op_e               op,
  input  logic [DATA_WIDTH-1:0] old_val,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] new_val
);

  always_comb begin
    new_val = old_val;
    unique case (op)
      OP_WRITE: new_val = operand;
      OP_SET:   new_val = old_val | operand;
      OP_CLR:   new_val = old_val & ~operand;
      OP_TGL:   new_val = old_val ^ operand;
      default:  new_val = old_val;
    endcase
  end

endmodule

// File: rtl/sfr_access_unit.sv
// Execute-stage SFR front end: sequences sfr_file read/write ports for
// read, write and atomic read-modify-write ops, one request at a time.
module sfr_access_unit
  import banff_sfr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SFR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SFR_DATA_WIDTH,
  parameter int unsigned SFR_DEPTH  = SFR_DEPTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  sfr_rd_en,
  output logic [ADDR_WIDTH-1:0] sfr_rd_addr,
  input  logic [DATA_WIDTH-1:0] sfr_rd_data,
  output logic                  sfr_wr_en,
  output logic [ADDR_WIDTH-1:0] sfr_wr_addr,
  output logic [DATA_WIDTH-1:0] sfr_wr_data
);

  sfr_state_e            state_q, state_d;
  sfr_op_e               op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [31:0]           addr_ext;
  logic                  req_legal;
  logic [DATA_WIDTH-1:0] rmw_val;

  // Unsigned range check done at 32 bits so a wide address bus can reach SFR_DEPTH.
  assign addr_ext  = 32'(req_addr);
  assign req_legal = op_is_legal(req_op) && (addr_ext < 32'(SFR_DEPTH));

  // Read data feeds the bit operation directly so the write strobe lands one cycle after capture.
  sfr_bitop #(.DATA_WIDTH(DATA_WIDTH)) u_bitop (
    .op      (op_q),
    .old_val (sfr_rd_data),
    .operand (data_q),
    .new_val (rmw_val)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d        = sfr_op_e'(req_op);
          addr_d      = req_addr;
          data_d      = req_data;
          req_ready_d = 1'b0;
          if (!req_legal) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else if (req_op == OP_WRITE) begin
            state_d     = ST_WRITE;
            wr_en_d     = 1'b1;
            wr_addr_d   = req_addr;
            wr_data_d   = req_data;
            resp_data_d = req_data;
          end else begin
            state_d   = ST_ISSUE;
            rd_en_d   = 1'b1;
            rd_addr_d = req_addr;
          end
        end
      end
      ST_ISSUE: state_d = ST_DATA;
      ST_DATA: begin
        if (op_q == OP_READ) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = sfr_rd_data;
        end else begin
          state_d     = ST_WRITE;
          wr_en_d     = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = rmw_val;
          resp_data_d = rmw_val;
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_READ;
      addr_q       <= '0;
      data_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign sfr_rd_en   = rd_en_q;
  assign sfr_rd_addr = rd_addr_q;
  assign sfr_wr_en   = wr_en_q;
  assign sfr_wr_addr = wr_addr_q;
  assign sfr_wr_data = wr_data_q;

endmodule

// File: tb/tb_sfr_access_unit.sv
// Directed self-checking bench for sfr_access_unit with a behavioural SFR file
// (one-cycle read latency); address bus widened to 7 bits so address 64 is expressible.
module tb_sfr_access_unit;

  localparam int AW = 7;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'b000;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic          sfr_rd_en;
  logic [AW-1:0] sfr_rd_addr;
  logic [DW-1:0] sfr_rd_data = '0;
  logic          sfr_wr_en;
  logic [AW-1:0] sfr_wr_addr;
  logic [DW-1:0] sfr_wr_data;

  logic [DW-1:0] mem [0:127];
  logic          tb_wr_en = 1'b0;
  logic [AW-1:0] tb_wr_addr = '0;
  logic [DW-1:0] tb_wr_data = '0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;

  int checks = 0;
  int errors = 0;

  sfr_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SFR_DEPTH(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .sfr_rd_en   (sfr_rd_en),
    .sfr_rd_addr (sfr_rd_addr),
    .sfr_rd_data (sfr_rd_data),
    .sfr_wr_en   (sfr_wr_en),
    .sfr_wr_addr (sfr_wr_addr),
    .sfr_wr_data (sfr_wr_data)
  );

  always #5 clock = ~clock;

  // Behavioural SFR file plus strobe counters.
  always @(posedge clock) begin
    if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
    else if (sfr_wr_en) mem[sfr_wr_addr] <= sfr_wr_data;
    if (sfr_rd_en) sfr_rd_data <= mem[sfr_rd_addr];
    if (sfr_rd_en) rd_cnt <= rd_cnt + 1;
    if (sfr_wr_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clock);
    tb_wr_en = 1'b1; tb_wr_addr = a; tb_wr_data = v;
    @(negedge clock);
    tb_wr_en = 1'b0;
  endtask

  // Waits (bounded) for req_ready, presents one request and returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_timeout req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_resp rdy=%b vld=%b err=%b data=%h required 1 0 0 00",
               req_ready, resp_valid, resp_err, resp_data);
    end
    checks++;
    if (sfr_rd_en !== 1'b0 || sfr_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes rd=%b wr=%b required 0 0", sfr_rd_en, sfr_wr_en);
    end
    reset = 1'b0;
  endtask

  task automatic test_read;
    logic rd [1:3];
    logic vld [1:3];
    int   w0;
    preload(7'h05, 8'h3C);
    w0 = wr_cnt;
    send(3'b000, 7'h05, 8'hFF);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      rd[k] = sfr_rd_en; vld[k] = resp_valid;
    end
    checks++;
    if (rd[1] !== 1'b1 || rd[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_rd_strobe t1=%b t2=%b required 1 0", rd[1], rd[2]);
    end
    checks++;
    if (vld[2] !== 1'b0 || vld[3] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_resp_timing t2=%b t3=%b required 0 1", vld[2], vld[3]);
    end
    checks++;
    if (resp_data !== 8'h3C || resp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_data data=%h err=%b required 3c 0", resp_data, resp_err);
    end
    checks++;
    if (wr_cnt != w0) begin
      errors++;
      $display("[TB] FAIL read_no_write writes=%0d required 0", wr_cnt - w0);
    end
  endtask

  task automatic test_rmw;
    logic [2:0] ops  [3] = '{3'b010, 3'b011, 3'b100};
    logic [7:0] mask [3] = '{8'h0F, 8'h80, 8'hFF};
    logic [7:0] expv [3] = '{8'hAF, 8'h20, 8'h5F};
    logic       rd [1:4];
    logic       wr [1:4];
    logic       vld [1:4];
    logic [7:0] wdat;
    int         w0;
    for (int i = 0; i < 3; i++) begin
      preload(7'h10, 8'hA0);
      w0 = wr_cnt;
      wdat = 8'h00;
      send(ops[i], 7'h10, mask[i]);
      for (int k = 1; k <= 4; k++) begin
        @(negedge clock);
        rd[k] = sfr_rd_en; wr[k] = sfr_wr_en; vld[k] = resp_valid;
        if (k == 3) wdat = sfr_wr_data;
      end
      checks++;
      if (rd[1] !== 1'b1 || wr[1] !== 1'b0 || wr[2] !== 1'b0 || wr[3] !== 1'b1 || wr[4] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rmw%0d_strobes rd1=%b wr=%b%b%b%b required 1 0010", i, rd[1], wr[1], wr[2], wr[3], wr[4]);
      end
      checks++;
      if (wdat !== expv[i] || wr_cnt - w0 != 1) begin
        errors++;
        $display("[TB] FAIL rmw%0d_wdata data=%h writes=%0d required %h 1", i, wdat, wr_cnt - w0, expv[i]);
      end
      checks++;
      if (vld[3] !== 1'b0 || vld[4] !== 1'b1 || resp_data !== expv[i] || resp_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rmw%0d_resp v3=%b v4=%b data=%h err=%b required 0 1 %h 0",
                 i, vld[3], vld[4], resp_data, resp_err, expv[i]);
      end
    end
  endtask

  task automatic test_write;
    int r0;
    logic [7:0] wdat;
    logic [6:0] wadr;
    logic       wr1, vld1;
    r0 = rd_cnt;
    send(3'b001, 7'h3F, 8'h77);
    @(negedge clock);
    wr1 = sfr_wr_en; wdat = sfr_wr_data; wadr = sfr_wr_addr; vld1 = resp_valid;
    @(negedge clock);
    checks++;
    if (wr1 !== 1'b1 || wdat !== 8'h77 || wadr !== 7'h3F) begin
      errors++;
      $display("[TB] FAIL write_strobe wr=%b data=%h addr=%h required 1 77 3f", wr1, wdat, wadr);
    end
    checks++;
    if (vld1 !== 1'b0 || resp_valid !== 1'b1 || resp_data !== 8'h77 || rd_cnt != r0) begin
      errors++;
      $display("[TB] FAIL write_resp v1=%b v2=%b data=%h reads=%0d required 0 1 77 0",
               vld1, resp_valid, resp_data, rd_cnt - r0);
    end
  endtask

  task automatic test_illegal;
    logic [2:0] ops  [2] = '{3'b110, 3'b000};
    logic [6:0] adrs [2] = '{7'h00, 7'd64};
    int r0, w0;
    for (int i = 0; i < 2; i++) begin
      r0 = rd_cnt; w0 = wr_cnt;
      send(ops[i], adrs[i], 8'h5A);
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 8'h00) begin
        errors++;
        $display("[TB] FAIL illegal%0d_resp vld=%b err=%b data=%h required 1 1 00", i, resp_valid, resp_err, resp_data);
      end
      @(negedge clock);
      checks++;
      if (rd_cnt != r0 || wr_cnt != w0 || resp_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL illegal%0d_strobes reads=%0d writes=%0d err_after=%b required 0 0 0",
                 i, rd_cnt - r0, wr_cnt - w0, resp_err);
      end
    end
    send(3'b000, 7'h3F, 8'h00);
    repeat (3) @(negedge clock);
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 8'h77) begin
      errors++;
      $display("[TB] FAIL top_addr_read vld=%b err=%b data=%h required 1 0 77", resp_valid, resp_err, resp_data);
    end
  endtask

  task automatic test_backpressure;
    int r0, w0;
    preload(7'h22, 8'h5A);
    resp_ready = 1'b0;
    send(3'b000, 7'h22, 8'h00);
    repeat (3) @(negedge clock);
    r0 = rd_cnt; w0 = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 8'h5A || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold%0d vld=%b data=%h rdy=%b required 1 5a 0", k, resp_valid, resp_data, req_ready);
      end
      @(negedge clock);
    end
    checks++;
    if (rd_cnt != r0 || wr_cnt != w0) begin
      errors++;
      $display("[TB] FAIL hold_traffic reads=%0d writes=%0d required 0 0", rd_cnt - r0, wr_cnt - w0);
    end
    resp_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL consume_cycle_ready rdy=%b required 0", req_ready);
    end
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_consume rdy=%b vld=%b required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid;
    int w0;
    preload(7'h10, 8'hA0);
    w0 = wr_cnt;
    send(3'b010, 7'h10, 8'h0F);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (sfr_wr_en !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid wr=%b rdy=%b vld=%b required 0 1 0", sfr_wr_en, req_ready, resp_valid);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (wr_cnt != w0 || mem[7'h10] !== 8'hA0 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_nowrite writes=%0d mem=%h vld=%b required 0 a0 0",
               wr_cnt - w0, mem[7'h10], resp_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    test_reset();
    test_read();
    test_rmw();
    test_write();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
